// File: rtl/branch_feedback_queue.sv
// Branch feedback queue: buffers committed branch outcomes from the ROB and
// drains them in commit order into the predictor's feedback port whenever
// the fetcher is not requesting a prediction. Also keeps saturating counts
// of accepted and mispredicted branches for performance debug.
module branch_feedback_queue #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_WIDTH  = 3
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  RBBF_commit_en,
  input  logic [ADDR_WIDTH-1:0] RBBF_pc,
  input  logic                  RBBF_taken,
  input  logic                  RBBF_mispredict,
  output logic                  BFRB_full,
  input  logic                  IFPD_predict_en,
  output logic                  BFPD_feedback_en,
  output logic                  BFPD_branch_result,
  output logic [ADDR_WIDTH-1:0] BFPD_feedback_pc,
  output logic [31:0]           BF_branch_cnt,
  output logic [31:0]           BF_mispredict_cnt
);

  localparam int unsigned CNT_WIDTH  = PTR_WIDTH + 1;
  localparam int unsigned STAT_WIDTH = 32;

  logic [ADDR_WIDTH-1:0] pc_mem [DEPTH];
  logic [DEPTH-1:0]      taken_mem;

  logic [PTR_WIDTH-1:0]  head;
  logic [PTR_WIDTH-1:0]  tail;
  logic [CNT_WIDTH-1:0]  count;

  logic                  push;
  logic                  pop;

  // Full and feedback-valid decode from registered occupancy; no bypass path.
  always_comb begin
    BFRB_full          = (count == CNT_WIDTH'(DEPTH));
    BFPD_feedback_en   = (count != '0) & ~IFPD_predict_en & Sys_rdy;
    push               = RBBF_commit_en & ~BFRB_full & Sys_rdy;
    pop                = BFPD_feedback_en;
    BFPD_branch_result = taken_mem[head];
    BFPD_feedback_pc   = pc_mem[head];
  end

  // Entry storage is not reset; only occupancy tracking makes entries live.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst && push) begin
      pc_mem[tail]    <= RBBF_pc;
      taken_mem[tail] <= RBBF_taken;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**PTR_WIDTH.
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_WIDTH'(1);
      if (pop)  head <= head + PTR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating performance counters, bumped only on accepted commits.
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst) begin
      BF_branch_cnt     <= '0;
      BF_mispredict_cnt <= '0;
    end else if (push) begin
      if (BF_branch_cnt != '1)
        BF_branch_cnt <= BF_branch_cnt + STAT_WIDTH'(1);
      if (RBBF_mispredict && (BF_mispredict_cnt != '1))
        BF_mispredict_cnt <= BF_mispredict_cnt + STAT_WIDTH'(1);
    end
  end

endmodule
